pwm_multi: RTL

- Multi-channel successor to the single-channel `pwm` generator that drives the AUX buffer path.
- NUM_CH independent channels, each with its own on-period and off-period in ticks, output inversion and enable.
- A shared prescaler generates the tick that advances every channel.
- On/off values are written through one register-write port into shadow registers. They become active only at a period boundary, so a new setting never produces a truncated or runt pulse.
- Outputs feed iobuf data inputs (AUX, CS, etc.) at the top level.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_channel.sv | 113 +++++++++++
 rtl/pwm_multi.sv | 63 ++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the multi-channel PWM block.
package pwm_pkg;

  // Register-write field selectors
  localparam logic [1:0] SEL_ON       = 2'd0;
  localparam logic [1:0] SEL_OFF      = 2'd1;
  localparam logic [1:0] SEL_CTRL     = 2'd2;
  localparam logic [1:0] SEL_PRESCALE = 2'd3;

  // Bit positions inside a SEL_CTRL write
  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_INV_BIT = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StOff  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active period registers, on/off FSM, down-counter
// and registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tick_i,
  input  logic                sync_i,
  input  logic                wr_on_i,
  input  logic                wr_off_i,
  input  logic                wr_ctrl_i,
  input  logic [CntWidth-1:0] wr_data_i,
  output logic                pwm_o,
  output logic                period_done_o,
  output logic                busy_o
);

  logic [CntWidth-1:0] shadow_on_q, shadow_off_q;
  logic [CntWidth-1:0] active_on_q, active_off_q;
  logic [CntWidth-1:0] cnt_q;
  logic                en_q, inv_q, en_d, inv_d;
  logic                pwm_q, period_done_q;
  pwm_state_e          state_q;

  pwm_state_e          start_state;
  logic [CntWidth-1:0] start_cnt;
  logic                cnt_zero, period_end, start_now;

  // Control bits act on the same edge they are written.
  assign en_d  = wr_ctrl_i ? wr_data_i[CTRL_EN_BIT]  : en_q;
  assign inv_d = wr_ctrl_i ? wr_data_i[CTRL_INV_BIT] : inv_q;

  // A period always starts from the pre-write shadow values. A 0/0 setting
  // parks in OFF with a zero count so every tick closes a period.
  assign start_state = (shadow_on_q != '0) ? StOn : StOff;
  assign start_cnt   = (shadow_on_q != '0)  ? shadow_on_q - CntWidth'(1) :
                       (shadow_off_q != '0) ? shadow_off_q - CntWidth'(1) : '0;

  assign cnt_zero   = (cnt_q == '0);
  assign period_end = tick_i && cnt_zero &&
                      ((state_q == StOff) || ((state_q == StOn) && (active_off_q == '0)));
  assign start_now  = sync_i || (tick_i && (state_q == StIdle)) || period_end;

  // Shadow and control registers, written from the shared write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_on_q  <= '0;
      shadow_off_q <= '0;
      en_q         <= 1'b0;
      inv_q        <= 1'b0;
    end else begin
      if (wr_on_i)  shadow_on_q  <= wr_data_i;
      if (wr_off_i) shadow_off_q <= wr_data_i;
      en_q  <= en_d;
      inv_q <= inv_d;
    end
  end

  // Channel FSM with registered output and period strobe; disable beats sync.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      active_on_q   <= '0;
      active_off_q  <= '0;
      pwm_q         <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      period_done_q <= 1'b0;
      if (!en_d) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        pwm_q   <= inv_d;
      end else if (start_now) begin
        active_on_q   <= shadow_on_q;
        active_off_q  <= shadow_off_q;
        state_q       <= start_state;
        cnt_q         <= start_cnt;
        pwm_q         <= (start_state == StOn) ^ inv_d;
        period_done_q <= period_end && !sync_i;
      end else if (tick_i) begin
        unique case (state_q)
          StOn: begin
            if (cnt_zero) begin
              // period_end covers the off==0 case, so off is non-zero here
              state_q <= StOff;
              cnt_q   <= active_off_q - CntWidth'(1);
              pwm_q   <= inv_d;
            end else begin
              cnt_q <= cnt_q - CntWidth'(1);
              pwm_q <= ~inv_d;
            end
          end
          StOff: begin
            cnt_q <= cnt_q - CntWidth'(1);
            pwm_q <= inv_d;
          end
          default: pwm_q <= inv_d;
        endcase
      end else begin
        pwm_q <= (state_q == StOn) ^ inv_d;
      end
    end
  end

  assign pwm_o         = pwm_q;
  assign period_done_o = period_done_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaler, register-write decode and
// an array of independent channels.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned PRE_WIDTH = 8,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_ch,
  input  logic [1:0]           wr_sel,
  input  logic [CNT_WIDTH-1:0] wr_data,
  input  logic                 sync,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic [NUM_CH-1:0]    period_done,
  output logic [NUM_CH-1:0]    busy
);

  logic [PRE_WIDTH-1:0] prescale_q, pre_cnt_q;
  logic                 tick, wr_prescale;

  assign tick        = (pre_cnt_q == prescale_q);
  assign wr_prescale = wr_en && (wr_sel == SEL_PRESCALE);

  // Shared prescaler; sync and a new prescale value both realign it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescale_q <= '0;
      pre_cnt_q  <= '0;
    end else begin
      if (wr_prescale) prescale_q <= wr_data[PRE_WIDTH-1:0];
      if (wr_prescale || sync || tick) pre_cnt_q <= '0;
      else                             pre_cnt_q <= pre_cnt_q + PRE_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    // Out-of-range channel numbers never match any instance.
    assign hit = wr_en && (wr_ch == CH_W'(i));

    pwm_channel #(
      .CntWidth(CNT_WIDTH)
    ) u_ch (
      .clk_i        (clock),
      .rst_ni       (reset),
      .tick_i       (tick),
      .sync_i       (sync),
      .wr_on_i      (hit && (wr_sel == SEL_ON)),
      .wr_off_i     (hit && (wr_sel == SEL_OFF)),
      .wr_ctrl_i    (hit && (wr_sel == SEL_CTRL)),
      .wr_data_i    (wr_data),
      .pwm_o        (pwm_out[i]),
      .period_done_o(period_done[i]),
      .busy_o       (busy[i])
    );
  end

endmodule
